// File: rtl/vga_timing_gen.sv
// VGA timing generator: divides clk down to a pixel clock-enable and walks x/y
// over the full raster, with registered sync, blanking and line/frame markers.
module vga_timing_gen #(
    parameter int   CLK_DIV   = 4,
    parameter int   H_ACTIVE  = 640,
    parameter int   H_FP      = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BP      = 48,
    parameter int   V_ACTIVE  = 480,
    parameter int   V_FP      = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BP      = 33,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    parameter int   CW        = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic          pix_ce,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Refuse to build a generator whose counters cannot hold a full line/frame.
    generate
        if ((longint'(1) << CW) < longint'(H_TOTAL) || (longint'(1) << CW) < longint'(V_TOTAL)) begin : g_cw_too_small
            $error("vga_timing_gen: CW too small for H_TOTAL/V_TOTAL");
        end
        if (CLK_DIV < 1) begin : g_bad_div
            $error("vga_timing_gen: CLK_DIV must be >= 1");
        end
    endgenerate

    logic [DW-1:0] div_reg;
    logic [DW-1:0] div_next;
    logic [CW-1:0] x_reg;
    logic [CW-1:0] x_next;
    logic [CW-1:0] y_reg;
    logic [CW-1:0] y_next;
    logic          tick;
    logic          pix_ce_reg;
    logic          hsync_reg;
    logic          hsync_next;
    logic          vsync_reg;
    logic          vsync_next;
    logic          video_on_reg;
    logic          video_on_next;
    logic          line_start_reg;
    logic          line_start_next;
    logic          frame_start_reg;
    logic          frame_start_next;

    assign tick = en && (div_reg == DIV_LAST);

    always_comb begin
        div_next = tick ? '0 : div_reg + 1'b1;
        x_next   = x_reg;
        y_next   = y_reg;
        if (tick) begin
            if (x_reg == H_LAST) begin
                x_next = '0;
                y_next = (y_reg == V_LAST) ? '0 : y_reg + 1'b1;
            end else begin
                x_next = x_reg + 1'b1;
            end
        end
    end

    // Outputs decode the position being loaded, so they change together with x/y.
    always_comb begin
        hsync_next       = ((x_next >= HS_FIRST) && (x_next <= HS_LAST)) ? HSYNC_POL : ~HSYNC_POL;
        vsync_next       = ((y_next >= VS_FIRST) && (y_next <= VS_LAST)) ? VSYNC_POL : ~VSYNC_POL;
        video_on_next    = (x_next < H_VIS) && (y_next < V_VIS);
        line_start_next  = (x_next == '0);
        frame_start_next = (x_next == '0) && (y_next == '0);
    end

    // Reset parks the raster on its last pixel so the first tick opens a new frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_reg         <= '0;
            x_reg           <= H_LAST;
            y_reg           <= V_LAST;
            pix_ce_reg      <= 1'b0;
            hsync_reg       <= ~HSYNC_POL;
            vsync_reg       <= ~VSYNC_POL;
            video_on_reg    <= 1'b0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            pix_ce_reg <= tick;
            if (en) begin
                div_reg <= div_next;
            end
            if (tick) begin
                x_reg           <= x_next;
                y_reg           <= y_next;
                hsync_reg       <= hsync_next;
                vsync_reg       <= vsync_next;
                video_on_reg    <= video_on_next;
                line_start_reg  <= line_start_next;
                frame_start_reg <= frame_start_next;
            end
        end
    end

    assign pix_ce      = pix_ce_reg;
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign video_on    = video_on_reg;
    assign x           = x_reg;
    assign y           = y_reg;
    assign line_start  = line_start_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing on one instance, a tiny raster with
// CLK_DIV=1 and positive hsync on a second instance.
module tb_vga_timing_gen;

    logic       clk = 1'b0;
    logic       a_rst_n, a_en, b_rst_n, b_en;
    logic       a_pix_ce, a_hsync, a_vsync, a_video_on, a_line_start, a_frame_start;
    logic [9:0] a_x, a_y;
    logic       b_pix_ce, b_hsync, b_vsync, b_video_on, b_line_start, b_frame_start;
    logic [3:0] b_x, b_y;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vga_timing_gen dut_a (
        .clk(clk), .rst_n(a_rst_n), .en(a_en),
        .pix_ce(a_pix_ce), .hsync(a_hsync), .vsync(a_vsync), .video_on(a_video_on),
        .x(a_x), .y(a_y), .line_start(a_line_start), .frame_start(a_frame_start)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .CW(4)
    ) dut_b (
        .clk(clk), .rst_n(b_rst_n), .en(b_en),
        .pix_ce(b_pix_ce), .hsync(b_hsync), .vsync(b_vsync), .video_on(b_video_on),
        .x(b_x), .y(b_y), .line_start(b_line_start), .frame_start(b_frame_start)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pce_cnt, fs_cnt, hs_low_cnt, vo_cnt, ls_cnt, first_pce_k, second_pce_k, ls_rise_k;
        int hs_first_x, hs_last_x, vo_fall_x, rule_err, vs_low_cnt, hs_high_cnt;
        logic prev_vo, prev_ls;
        logic [9:0] hold_x, hold_y;
        logic [4:0] hold_out;

        a_rst_n = 1'b0; a_en = 1'b1; b_rst_n = 1'b0; b_en = 1'b1;
        step(); step();

        // ---- default instance: reset state ----
        check_val("a_rst_x", a_x, 799);
        check_val("a_rst_y", a_y, 524);
        check_val("a_rst_video_on", a_video_on, 0);
        check_val("a_rst_hsync", a_hsync, 1);
        check_val("a_rst_vsync", a_vsync, 1);
        check_val("a_rst_pix_ce", a_pix_ce, 0);
        check_val("a_rst_line_start", a_line_start, 0);
        check_val("a_rst_frame_start", a_frame_start, 0);

        // ---- release and observe the first line ----
        a_rst_n = 1'b1;
        pce_cnt = 0; fs_cnt = 0; hs_low_cnt = 0; vo_cnt = 0;
        first_pce_k = -1; second_pce_k = -1; ls_rise_k = -1;
        hs_first_x = -1; hs_last_x = -1; vo_fall_x = -1;
        prev_vo = 1'b0; prev_ls = 1'b0;
        for (int k = 1; k <= 3210; k++) begin
            step();
            if (k == 4) begin
                check_val("a_first_x", a_x, 0);
                check_val("a_first_y", a_y, 0);
                check_val("a_first_video_on", a_video_on, 1);
                check_val("a_first_line_start", a_line_start, 1);
                check_val("a_first_frame_start", a_frame_start, 1);
            end
            if (k == 5) check_val("a_pix_ce_one_clk", a_pix_ce, 0);
            if (a_pix_ce) begin
                if (first_pce_k < 0) first_pce_k = k;
                else if (second_pce_k < 0) second_pce_k = k;
            end
            if (k <= 3203) begin
                if (a_pix_ce) pce_cnt++;
                if (a_frame_start) fs_cnt++;
                if (a_video_on) vo_cnt++;
                if (!a_hsync) begin
                    hs_low_cnt++;
                    if (hs_first_x < 0) hs_first_x = int'(a_x);
                    hs_last_x = int'(a_x);
                end
                if (prev_vo && !a_video_on && vo_fall_x < 0) vo_fall_x = int'(a_x);
            end
            if (k > 4 && !prev_ls && a_line_start && ls_rise_k < 0) begin
                ls_rise_k = k;
                check_val("a_line1_y", a_y, 1);
            end
            prev_vo = a_video_on;
            prev_ls = a_line_start;
        end
        check_val("a_first_pce_edge", first_pce_k, 4);
        check_val("a_pce_period", second_pce_k - first_pce_k, 4);
        check_val("a_pce_per_line", pce_cnt, 800);
        check_val("a_frame_start_clks", fs_cnt, 4);
        check_val("a_video_on_clks", vo_cnt, 2560);
        check_val("a_hsync_low_clks", hs_low_cnt, 384);
        check_val("a_hsync_first_x", hs_first_x, 656);
        check_val("a_hsync_last_x", hs_last_x, 751);
        check_val("a_video_fall_x", vo_fall_x, 640);
        check_val("a_line_period", ls_rise_k - 4, 3200);

        // ---- freeze with en low at x=100 ----
        for (int i = 0; i < 4000 && !(a_x == 10'd100 && a_pix_ce); i++) step();
        check_val("a_reach_x100", a_x, 100);
        step(); step();
        hold_x = a_x; hold_y = a_y;
        hold_out = {a_hsync, a_vsync, a_video_on, a_line_start, a_frame_start};
        a_en = 1'b0;
        pce_cnt = 0; rule_err = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (a_pix_ce) pce_cnt++;
            if (a_x != hold_x || a_y != hold_y ||
                {a_hsync, a_vsync, a_video_on, a_line_start, a_frame_start} != hold_out) rule_err++;
        end
        check_val("a_freeze_pce", pce_cnt, 0);
        check_val("a_freeze_changes", rule_err, 0);
        check_val("a_freeze_x", a_x, 100);
        a_en = 1'b1;
        step();
        check_val("a_resume1_x", a_x, 100);
        check_val("a_resume1_pix_ce", a_pix_ce, 0);
        step();
        check_val("a_resume2_x", a_x, 101);
        check_val("a_resume2_pix_ce", a_pix_ce, 1);

        // ---- mid-frame reset at x=300 ----
        for (int i = 0; i < 4000 && a_x != 10'd300; i++) step();
        check_val("a_reach_x300", a_x, 300);
        a_rst_n = 1'b0;
        step();
        a_rst_n = 1'b1;
        check_val("a_midrst_x", a_x, 799);
        check_val("a_midrst_y", a_y, 524);
        check_val("a_midrst_video_on", a_video_on, 0);
        check_val("a_midrst_hsync", a_hsync, 1);
        check_val("a_midrst_vsync", a_vsync, 1);
        check_val("a_midrst_pix_ce", a_pix_ce, 0);
        step(); step(); step();
        check_val("a_restart3_x", a_x, 799);
        step();
        check_val("a_restart_x", a_x, 0);
        check_val("a_restart_y", a_y, 0);
        check_val("a_restart_frame_start", a_frame_start, 1);
        check_val("a_restart_pix_ce", a_pix_ce, 1);

        // ---- tiny raster, CLK_DIV=1, hsync active high ----
        check_val("b_rst_x", b_x, 11);
        check_val("b_rst_y", b_y, 6);
        check_val("b_rst_hsync", b_hsync, 0);
        check_val("b_rst_vsync", b_vsync, 1);
        b_rst_n = 1'b1;
        step();
        check_val("b_first_x", b_x, 0);
        check_val("b_first_frame_start", b_frame_start, 1);
        pce_cnt = 0; hs_high_cnt = 0; vs_low_cnt = 0; vo_cnt = 0; fs_cnt = 0; ls_cnt = 0; rule_err = 0;
        for (int k = 1; k <= 84; k++) begin
            if (b_pix_ce) pce_cnt++;
            if (b_hsync) hs_high_cnt++;
            if (!b_vsync) vs_low_cnt++;
            if (b_video_on) vo_cnt++;
            if (b_frame_start) fs_cnt++;
            if (b_line_start) ls_cnt++;
            if (b_hsync != (b_x == 4'd9 || b_x == 4'd10)) rule_err++;
            if (b_vsync != (b_y != 4'd5)) rule_err++;
            step();
        end
        check_val("b_pce_clks", pce_cnt, 84);
        check_val("b_hsync_high_clks", hs_high_cnt, 14);
        check_val("b_vsync_low_clks", vs_low_cnt, 12);
        check_val("b_video_on_clks", vo_cnt, 32);
        check_val("b_frame_start_clks", fs_cnt, 1);
        check_val("b_lines_per_frame", ls_cnt, 7);
        check_val("b_sync_rule_errs", rule_err, 0);
        check_val("b_next_frame_start", b_frame_start, 1);
        check_val("b_next_frame_xy", {b_x, b_y}, 0);

        // reset wins over en=0
        b_en = 1'b0; b_rst_n = 1'b0;
        step();
        check_val("b_rst_over_en_x", b_x, 11);
        check_val("b_rst_over_en_pix_ce", b_pix_ce, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
